// File: rtl/fpq_pkg.sv
// Shared types and default constants for the fixed-priority packet scheduler.
package fpq_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XMIT = 2'd1,
    ST_GAP  = 2'd2
  } fpq_state_e;

  localparam int FPQ_N_Q   = 4;
  localparam int FPQ_LEN_W = 8;
  localparam int FPQ_IFG   = 2;
  localparam int FPQ_CNT_W = 16;

endpackage

// File: rtl/fpq_sched_if.sv
// Transmit port of the scheduler.
// Handshake: a beat transfers on every cnt_clk edge where tx_valid and
// tx_ready are both high; while tx_valid is high and tx_ready is low the
// master holds tx_qid and tx_last stable and keeps tx_valid asserted.
interface fpq_sched_if #(
  parameter int QID_W = 2
) ();
  logic             tx_valid;
  logic             tx_ready;
  logic [QID_W-1:0] tx_qid;
  logic             tx_last;

  modport master (output tx_valid, output tx_qid, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_qid, input tx_last, output tx_ready);
endinterface

// File: rtl/fpq_prio_enc.sv
// Combinational priority encoder: lowest set request index wins.
module fpq_prio_enc #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top so the lowest-index requester is the last to overwrite.
  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/fpq_sched.sv
// Fixed-priority packet scheduler: grants the lowest-index non-empty queue,
// streams its packet as byte beats, then strobes go[] back to that queue.
module fpq_sched
  import fpq_pkg::*;
#(
  parameter  int N_Q   = FPQ_N_Q,
  parameter  int LEN_W = FPQ_LEN_W,
  parameter  int IFG   = FPQ_IFG,
  localparam int QID_W = (N_Q > 1) ? $clog2(N_Q) : 1
) (
  input  logic                 cnt_clk,
  input  logic                 rst,
  input  logic [N_Q*LEN_W-1:0] pkt_len,
  output logic [N_Q-1:0]       go,
  fpq_sched_if.master          tx,
  output logic                 busy,
  output logic [FPQ_CNT_W-1:0] pkt_cnt,
  output fpq_state_e           dbg_state
);

  localparam int GAP_W = 4;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG - 1);

  fpq_state_e           state_q, state_d;
  logic [QID_W-1:0]     sel_q, sel_d;
  logic [LEN_W-1:0]     remain_q, remain_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [FPQ_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [N_Q-1:0]   req;
  logic             req_any;
  logic [QID_W-1:0] req_idx;
  logic [LEN_W-1:0] win_len;
  logic             first_gap;

  // A lane requests service whenever its head length is non-zero.
  always_comb begin
    req = '0;
    for (int i = 0; i < N_Q; i++) begin
      req[i] = |pkt_len[i*LEN_W +: LEN_W];
    end
  end

  fpq_prio_enc #(.N(N_Q)) u_enc (
    .req_i (req),
    .any_o (req_any),
    .idx_o (req_idx)
  );

  // Select the winning lane's length without a variable part-select.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < N_Q; i++) begin
      if (req_idx == QID_W'(i)) win_len = pkt_len[i*LEN_W +: LEN_W];
    end
  end

  assign first_gap = (state_q == ST_GAP) && (gap_cnt_q == '0);

  // Next-state logic for the FSM and its counters.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    remain_d  = remain_q;
    gap_cnt_d = gap_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          sel_d    = req_idx;
          remain_d = win_len;
          state_d  = ST_XMIT;
        end
      end
      ST_XMIT: begin
        if (tx.tx_ready) begin
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (first_gap) pkt_cnt_d = pkt_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset abandons any packet in flight.
  always_ff @(posedge cnt_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      remain_q  <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      remain_q  <= remain_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    go = '0;
    if (first_gap) go[sel_q] = 1'b1;
  end

  assign tx.tx_valid = (state_q == ST_XMIT);
  assign tx.tx_last  = (state_q == ST_XMIT) && (remain_q == LEN_W'(1));
  assign tx.tx_qid   = sel_q;
  assign busy        = (state_q != ST_IDLE);
  assign pkt_cnt     = pkt_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fpq_sched.sv
// Directed bench for fpq_sched (N_Q=4, LEN_W=8, IFG=2).
module tb_fpq_sched;
  import fpq_pkg::*;

  localparam int IFG = 2;

  logic        cnt_clk;
  logic        rst;
  logic [31:0] pkt_len;
  logic [3:0]  go;
  logic        busy;
  logic [15:0] pkt_cnt;
  fpq_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int go_total = 0;

  fpq_sched_if #(.QID_W(2)) tx_if ();

  fpq_sched #(.N_Q(4), .LEN_W(8), .IFG(IFG)) dut (
    .cnt_clk   (cnt_clk),
    .rst       (rst),
    .pkt_len   (pkt_len),
    .go        (go),
    .tx        (tx_if),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial cnt_clk = 1'b0;
  always #5 cnt_clk = ~cnt_clk;

  // Count every cycle with any go bit high, sampled mid-cycle.
  always @(negedge cnt_clk) if (go != 4'b0) go_total++;

  // Advance one cycle; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge cnt_clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    pkt_len[i*8 +: 8] = v;
  endtask

  // Driver/collector: waits for tx_valid, counts accepted beats until the
  // tx_last beat is accepted, returns positioned in the cycle after it.
  task automatic collect_pkt(input int max_cyc, output int beats, output int qid,
                             output int wait_cyc, output bit qid_steady);
    int cyc;
    cyc = 0; beats = 0; qid = -1; wait_cyc = 0; qid_steady = 1'b1;
    while (!tx_if.tx_valid && cyc < max_cyc) begin
      tick(); cyc++; wait_cyc++;
    end
    while (cyc < max_cyc) begin
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        beats++;
        if (qid < 0) qid = int'(tx_if.tx_qid);
        else if (qid != int'(tx_if.tx_qid)) qid_steady = 1'b0;
        if (tx_if.tx_last) begin
          tick();
          break;
        end
      end
      tick(); cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pkt_len = '0; tx_if.tx_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", tx_if.tx_valid); end
    n_tests++; if (tx_if.tx_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got=%b exp=0", tx_if.tx_last); end
    n_tests++; if (tx_if.tx_qid !== 2'd0) begin n_fail++; $display("FAIL rst_qid got=%0d exp=0", tx_if.tx_qid); end
    n_tests++; if (go !== 4'b0) begin n_fail++; $display("FAIL rst_go got=%b exp=0000", go); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_tests++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", pkt_cnt); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_single();
    int beats, qid, wc; bit st;
    set_lane(0, 8'd3);
    collect_pkt(20, beats, qid, wc, st);
    set_lane(0, 8'd0);
    n_tests++; if (wc != 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=1", wc); end
    n_tests++; if (beats != 3) begin n_fail++; $display("FAIL single_beats got=%0d exp=3", beats); end
    n_tests++; if (qid != 0 || !st) begin n_fail++; $display("FAIL single_qid got=%0d steady=%0d exp=0", qid, st); end
    n_tests++; if (go !== 4'b0001) begin n_fail++; $display("FAIL single_go got=%b exp=0001", go); end
    tick();
    n_tests++; if (go !== 4'b0000) begin n_fail++; $display("FAIL single_go_once got=%b exp=0000", go); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_gap_busy got=%b exp=1", busy); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", busy); end
    n_tests++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic test_priority();
    int beats, qid, wc; bit st;
    set_lane(2, 8'd2); set_lane(1, 8'd5);
    collect_pkt(30, beats, qid, wc, st);
    set_lane(1, 8'd0);
    n_tests++; if (beats != 5 || qid != 1 || !st) begin n_fail++; $display("FAIL prio_first got=%0d beats q%0d exp=5 beats q1", beats, qid); end
    n_tests++; if (go !== 4'b0010) begin n_fail++; $display("FAIL prio_go1 got=%b exp=0010", go); end
    collect_pkt(30, beats, qid, wc, st);
    set_lane(2, 8'd0);
    n_tests++; if (wc != IFG + 1) begin n_fail++; $display("FAIL prio_gap got=%0d exp=%0d", wc, IFG + 1); end
    n_tests++; if (beats != 2 || qid != 2 || !st) begin n_fail++; $display("FAIL prio_second got=%0d beats q%0d exp=2 beats q2", beats, qid); end
    n_tests++; if (go !== 4'b0100) begin n_fail++; $display("FAIL prio_go2 got=%b exp=0100", go); end
    repeat (IFG) tick();
    n_tests++; if (pkt_cnt !== 16'd3) begin n_fail++; $display("FAIL prio_cnt got=%0d exp=3", pkt_cnt); end
  endtask

  task automatic test_nonpreempt();
    int beats, qid, wc; bit st;
    set_lane(3, 8'd4);
    tick();
    n_tests++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_qid !== 2'd3 || tx_if.tx_last !== 1'b0) begin
      n_fail++; $display("FAIL np_beat1 got=v%b q%0d l%b exp=v1 q3 l0", tx_if.tx_valid, tx_if.tx_qid, tx_if.tx_last); end
    tick();
    set_lane(0, 8'd1);
    collect_pkt(20, beats, qid, wc, st);
    set_lane(3, 8'd0);
    n_tests++; if (beats != 3 || qid != 3 || !st) begin n_fail++; $display("FAIL np_rest got=%0d beats q%0d exp=3 beats q3", beats, qid); end
    n_tests++; if (go !== 4'b1000) begin n_fail++; $display("FAIL np_go3 got=%b exp=1000", go); end
    collect_pkt(20, beats, qid, wc, st);
    set_lane(0, 8'd0);
    n_tests++; if (beats != 1 || qid != 0) begin n_fail++; $display("FAIL np_q0 got=%0d beats q%0d exp=1 beats q0", beats, qid); end
    n_tests++; if (go !== 4'b0001) begin n_fail++; $display("FAIL np_go0 got=%b exp=0001", go); end
    repeat (IFG) tick();
    n_tests++; if (pkt_cnt !== 16'd5) begin n_fail++; $display("FAIL np_cnt got=%0d exp=5", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    int beats, qid, wc, g0; bit st;
    g0 = go_total;
    set_lane(1, 8'd5);
    tick(); tick();
    tick();
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_qid !== 2'd1 || tx_if.tx_last !== 1'b0 || go !== 4'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got=v%b q%0d l%b go%b exp=v1 q1 l0 go0000", i, tx_if.tx_valid, tx_if.tx_qid, tx_if.tx_last, go); end
      if (i < 2) tick();
    end
    tx_if.tx_ready = 1'b1;
    collect_pkt(20, beats, qid, wc, st);
    set_lane(1, 8'd0);
    n_tests++; if (beats != 3 || qid != 1 || !st) begin n_fail++; $display("FAIL bp_rest got=%0d beats q%0d exp=3 beats q1", beats, qid); end
    n_tests++; if (go !== 4'b0010) begin n_fail++; $display("FAIL bp_go got=%b exp=0010", go); end
    repeat (IFG) tick();
    n_tests++; if (go_total - g0 != 1) begin n_fail++; $display("FAIL bp_go_count got=%0d exp=1", go_total - g0); end
    n_tests++; if (pkt_cnt !== 16'd6) begin n_fail++; $display("FAIL bp_cnt got=%0d exp=6", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int g0;
    g0 = go_total;
    set_lane(2, 8'd6);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_lane(2, 8'd0);
    n_tests++; if (tx_if.tx_valid !== 1'b0 || tx_if.tx_last !== 1'b0 || tx_if.tx_qid !== 2'd0) begin
      n_fail++; $display("FAIL rm_tx got=v%b l%b q%0d exp=v0 l0 q0", tx_if.tx_valid, tx_if.tx_last, tx_if.tx_qid); end
    n_tests++; if (busy !== 1'b0 || go !== 4'b0) begin n_fail++; $display("FAIL rm_busy_go got=b%b go%b exp=b0 go0000", busy, go); end
    n_tests++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_cnt got=%0d exp=0", pkt_cnt); end
    repeat (5) tick();
    n_tests++; if (go_total != g0 || pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_after got=go%0d cnt%0d exp=go0 cnt0", go_total - g0, pkt_cnt); end
  endtask

  task automatic test_wrap_255();
    int beats, qid, wc; bit st;
    force dut.pkt_cnt_q = 16'hFFFF;
    tick();
    release dut.pkt_cnt_q;
    tick();
    n_tests++; if (pkt_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got=%0d exp=65535", pkt_cnt); end
    set_lane(0, 8'd255);
    collect_pkt(400, beats, qid, wc, st);
    set_lane(0, 8'd0);
    n_tests++; if (beats != 255 || qid != 0 || !st) begin n_fail++; $display("FAIL wrap_beats got=%0d beats q%0d exp=255 beats q0", beats, qid); end
    n_tests++; if (go !== 4'b0001) begin n_fail++; $display("FAIL wrap_go got=%b exp=0001", go); end
    repeat (IFG) tick();
    n_tests++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_cnt got=%0d exp=0", pkt_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    pkt_len = '0;
    tx_if.tx_ready = 1'b1;
    test_reset();
    test_single();
    test_priority();
    test_nonpreempt();
    test_backpressure();
    test_reset_mid();
    test_wrap_255();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
